dmem_ahb_slave: RTL and testbench
=================================

DMEM_AHB_SLAVE -- requirements
Module: dmem_ahb_slave

Interface
- REQ-001 SHALL have parameter ADDR_W, default 10; word-address width, giving a memory depth of 2**ADDR_W 32-bit words.
- REQ-002 SHALL have parameter WAIT_CYCLES, default 1; wait states inserted per data phase (0..15), used only when DMEM_WAIT_EN is defined.
- REQ-003 SHALL have port clk, input, 1; the single clock, rising edge.
- REQ-004 SHALL have port reset, input, 1; asynchronous, active-high.
- REQ-005 SHALL have port HSEL, input, 1; slave select.
- REQ-006 SHALL have port HADDR, input, 32; byte address.
- REQ-007 SHALL have port HTRANS, input, 2; 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- REQ-008 SHALL have port HWRITE, input, 1; 1 = write, 0 = read.
- REQ-009 SHALL have port HSIZE, input, 3; 000 byte, 001 halfword, 010 word.
- REQ-010 SHALL have port HBUST, input, 3; accepted and ignored, since every transfer is treated as a single transfer.
- REQ-011 SHALL have port HWDATA, input, 32; write data, sampled in the data phase.
- REQ-012 SHALL have port HRDATA, output, 32; the full aligned word, little-endian lanes, with lane selection left to the master.
- REQ-013 SHALL have port HREADY, output, 1; 1 = data phase completes this cycle.
- REQ-014 SHALL have port HRESP, output, 2; 00 OKAY, 01 ERROR.

Function
- REQ-015 SHALL accept an address phase when HSEL=1, HTRANS[1]=1 and HREADY=1 at a rising clk edge, registering address, write flag and size.
- REQ-016 SHALL answer IDLE/BUSY transfers, or HSEL=0, with zero-wait OKAY and no memory access.
- REQ-017 SHALL implement FSM states IDLE, DATA, ERR1, ERR2.
  - IDLE -> DATA on a valid accepted transfer.
  - IDLE -> ERR1 on an invalid accepted transfer.
  - DATA -> IDLE, DATA or ERR1 on the HREADY=1 cycle, according to the next accepted phase.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> IDLE, DATA or ERR1 according to the next accepted phase.
- REQ-018 SHALL treat a transfer as invalid when any of the following holds:
  - HSIZE > 010;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0] != 00;
  - HADDR[31:ADDR_W+2] != 0.
- REQ-019 SHALL, for an invalid transfer, drive ERR1 (HREADY=0, HRESP=01) followed by ERR2 (HREADY=1, HRESP=01), with no memory write.
- REQ-020 SHALL read synchronously: the word is addressed at the address-phase edge and HRDATA is valid in the first data-phase cycle with HREADY=1.
- REQ-021 SHALL commit a write at the edge ending its data phase, with byte enables derived from HSIZE and HADDR[1:0]: byte 0001<<a[1:0], halfword 0011<<a[1:0], word 1111.
- REQ-022 SHALL forward when a read address phase coincides with a write data phase to the same word: HRDATA returns the stored word merged with the enabled HWDATA bytes.
- REQ-023 SHALL hold HRDATA at its last value for writes, errors and idle cycles.

Reset
- REQ-024 SHALL, while reset=1, force state IDLE, HREADY=1, HRESP=00, HRDATA=0 and clear the wait counter, with memory contents not reset.
- REQ-025 SHALL, on reset asserted mid-transfer, abort the transfer and discard any pending write.

Configuration
- REQ-026 SHALL, with DMEM_WAIT_EN defined, hold HREADY=0, HRESP=00 for WAIT_CYCLES cycles at the start of each valid data phase, with HREADY=1 on the following cycle.
- REQ-027 SHALL, without DMEM_WAIT_EN, make every valid data phase zero-wait, ignore WAIT_CYCLES and synthesize no counter.
- REQ-028 SHALL keep error responses at exactly two cycles in both builds.

Structure
- REQ-029 SHALL place HTRANS, HSIZE and HRESP encodings and the FSM state typedef in shared package ahb_pkg, alongside the MAU.
- REQ-030 SHALL use one sub-module, dmem_sram: a single-port byte-enabled synchronous RAM of 2**ADDR_W x 32.

Verification
- REQ-031 SHALL cover word write then read: write 0x00000010 = 0xDEADBEEF, then read 0x10 -> HRDATA 0xDEADBEEF, HRESP 00.
- REQ-032 SHALL cover a byte write: write byte 0x55 at 0x13 over 0xDEADBEEF -> read of 0x10 returns 0x55ADBEEF.
- REQ-033 SHALL cover a misaligned access: word read at 0x12 -> ERR1 (HREADY=0, HRESP=01), then ERR2 (HREADY=1, HRESP=01), memory unchanged.
- REQ-034 SHALL cover back-to-back forwarding: write halfword 0xA5A5 at 0x20, immediately followed by a read of 0x20 -> low half 0xA5A5 in the first data phase.
- REQ-035 SHALL cover wait states: with DMEM_WAIT_EN and WAIT_CYCLES=2, a read gives HREADY 0, 0, 1; without the macro, HREADY stays 1.
- REQ-036 SHALL cover reset mid-write: reset asserted during a write data phase -> HREADY=1, HRESP=00, HRDATA=0, and the target word is unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane helpers for the data-memory slave.
package ahb_pkg;

    localparam int MAU_BITS       = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } dmem_state_e;

    function automatic logic [BYTES_PER_WORD-1:0] byte_en(input logic [2:0] size,
                                                          input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << lane;
            HSIZE_HALF: byte_en = 4'b0011 << lane;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Byte-enabled synchronous RAM, 2**ADDR_W x 32, one clock; read returns the pre-write word on a same-edge collision.
module dmem_sram
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    input  logic [BYTES_PER_WORD-1:0] be_i,
    input  logic [31:0]               wdata_i,
    input  logic                      re_i,
    input  logic [ADDR_W-1:0]         raddr_i,
    output logic [31:0]               rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][i*MAU_BITS +: MAU_BITS] <= wdata_i[i*MAU_BITS +: MAU_BITS];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ahb_slave.sv
// AHB-Lite data-memory slave with two-cycle error responses and read-after-write forwarding.
// Optional wait states per data phase are enabled by defining DMEM_WAIT_EN.
module dmem_ahb_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBUST,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP
);

    dmem_state_e               state_q, state_d;
    logic                      hready, accept, valid, data_rdy;
    logic [1:0]                hresp;
    logic [ADDR_W-1:0]         haddr_word, addr_q;
    logic                      wr_q;
    logic [BYTES_PER_WORD-1:0] be_q, fwd_be_q;
    logic [31:0]               fwd_data_q, ram_rdata, rd_word, hrdata_q;
    logic                      ram_we, ram_re, rd_done;
    logic                      unused_bits;

    assign haddr_word  = HADDR[ADDR_W+1:2];
    assign unused_bits = ^{HBUST, HTRANS[0]};

    always_comb begin
        valid = 1'b1;
        case (HSIZE)
            HSIZE_BYTE: valid = 1'b1;
            HSIZE_HALF: valid = ~HADDR[0];
            HSIZE_WORD: valid = (HADDR[1:0] == 2'b00);
            default:    valid = 1'b0;
        endcase
        if ((HADDR >> (ADDR_W + 2)) != 32'd0) begin
            valid = 1'b0;
        end
    end

`ifdef DMEM_WAIT_EN
    logic [3:0] wait_q, wait_d;

    // Reload at the start of every new data phase, count down while it stalls.
    always_comb begin
        wait_d = wait_q;
        if (state_d == ST_DATA && (state_q != ST_DATA || hready)) begin
            wait_d = WAIT_CYCLES[3:0];
        end else if (state_q == ST_DATA && wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_q <= 4'd0;
        else       wait_q <= wait_d;
    end

    assign data_rdy = (wait_q == 4'd0);
`else
    assign data_rdy = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        case (state_q)
            ST_IDLE: hready = 1'b1;
            ST_DATA: hready = data_rdy;
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: hready = 1'b1;
        endcase
        accept = HSEL && HTRANS[1] && hready;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (hready) begin
            state_d = accept ? (valid ? ST_DATA : ST_ERR1) : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_q     <= 1'b0;
            hrdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept && valid) wr_q <= HWRITE;
            if (rd_done)         hrdata_q <= rd_word;
        end
    end

    assign ram_we  = (state_q == ST_DATA) && wr_q && hready;
    assign ram_re  = accept && valid && !HWRITE;
    assign rd_done = (state_q == ST_DATA) && !wr_q && hready;

    // Address-phase capture; forwarding bytes are taken when a read is issued on the edge a write commits.
    always_ff @(posedge clk) begin
        if (accept && valid) begin
            addr_q <= haddr_word;
            be_q   <= byte_en(HSIZE, HADDR[1:0]);
        end
        if (ram_re) begin
            fwd_be_q   <= (ram_we && addr_q == haddr_word) ? be_q : '0;
            fwd_data_q <= HWDATA;
        end
    end

    always_comb begin
        rd_word = ram_rdata;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (fwd_be_q[i]) rd_word[i*MAU_BITS +: MAU_BITS] = fwd_data_q[i*MAU_BITS +: MAU_BITS];
        end
    end

    dmem_sram #(.ADDR_W(ADDR_W)) u_sram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (addr_q),
        .be_i    (be_q),
        .wdata_i (HWDATA),
        .re_i    (ram_re),
        .raddr_i (haddr_word),
        .rdata_o (ram_rdata)
    );

    assign HRDATA = rd_done ? rd_word : hrdata_q;
    assign HREADY = hready;
    assign HRESP  = hresp;

endmodule

// File: tb/tb_dmem_ahb_slave.sv
// Directed bench for dmem_ahb_slave; read data is checked through an expected-value queue.
module tb_dmem_ahb_slave;

`ifdef DMEM_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBUST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    dmem_ahb_slave #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .HSEL   (HSEL),
        .HADDR  (HADDR),
        .HTRANS (HTRANS),
        .HWRITE (HWRITE),
        .HSIZE  (HSIZE),
        .HBUST  (HBUST),
        .HWDATA (HWDATA),
        .HRDATA (HRDATA),
        .HREADY (HREADY),
        .HRESP  (HRESP)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic w, input logic [31:0] a, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a; HSIZE = sz;
    endtask

    task automatic drive_idle();
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HSIZE = 3'b010;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (HREADY !== 1'b1 && n < 20) begin
            n++;
            step();
        end
        check({tag, "_ready"}, {31'd0, HREADY}, 32'd1);
        check({tag, "_waits"}, n, EXP_WAIT);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e = 32'hFFFF_FFFF;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, "_rdata"}, HRDATA, e);
        check({tag, "_resp"}, {30'd0, HRESP}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        drive_addr(1'b0, a, 3'b010);
        step();
        drive_idle();
        wait_ready(tag);
        pop_check(tag);
        step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                            input string tag);
        drive_addr(1'b1, a, sz);
        step();
        drive_idle();
        HWDATA = d;
        wait_ready(tag);
        check({tag, "_resp"}, {30'd0, HRESP}, 32'd0);
        step();
        HWDATA = 32'h0;
    endtask

    task automatic do_err(input logic w, input logic [31:0] a, input logic [2:0] sz, input string tag);
        drive_addr(w, a, sz);
        step();
        drive_idle();
        HWDATA = 32'hFFFF_FFFF;
        check({tag, "_err1"}, {29'd0, HREADY, HRESP}, {29'd0, 1'b0, 2'b01});
        step();
        check({tag, "_err2"}, {29'd0, HREADY, HRESP}, {29'd0, 1'b1, 2'b01});
        step();
        check({tag, "_after"}, {29'd0, HREADY, HRESP}, {29'd0, 1'b1, 2'b00});
        HWDATA = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        HBUST = 3'b000;
        HWDATA = 32'h0;
        drive_idle();
        step();
        step();
        check("reset_hready", {31'd0, HREADY}, 32'd1);
        check("reset_hresp", {30'd0, HRESP}, 32'd0);
        check("reset_hrdata", HRDATA, 32'd0);
        reset = 1'b0;
        step();

        // Word write then read, with HRDATA holding across the write.
        do_write(32'h10, 3'b010, 32'hDEADBEEF, "wr_word");
        check("hold_after_write", HRDATA, 32'd0);
        do_read(32'h10, 32'hDEADBEEF, "rd_word");

        // Byte write into lane 3.
        do_write(32'h13, 3'b000, 32'h55000000, "wr_byte");
        check("hold_after_bytewr", HRDATA, 32'hDEADBEEF);
        do_read(32'h10, 32'h55ADBEEF, "rd_byte");

        // Error cases, none of which may touch memory.
        do_err(1'b0, 32'h12, 3'b010, "err_misaligned_rd");
        check("hold_after_err", HRDATA, 32'h55ADBEEF);
        do_err(1'b1, 32'h11, 3'b001, "err_half_odd_wr");
        do_err(1'b1, 32'h1010, 3'b010, "err_out_of_range_wr");
        do_err(1'b1, 32'h10, 3'b011, "err_bad_size_wr");
        do_read(32'h10, 32'h55ADBEEF, "rd_after_err");

        // Deselected and BUSY transfers: zero-wait OKAY, no write.
        HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'b010;
        step();
        HWDATA = 32'h0BAD0BAD;
        HSEL = 1'b1; HTRANS = 2'b01;
        check("nosel_ready_resp", {29'd0, HREADY, HRESP}, {29'd0, 1'b1, 2'b00});
        step();
        check("busy_ready_resp", {29'd0, HREADY, HRESP}, {29'd0, 1'b1, 2'b00});
        drive_idle();
        step();
        HWDATA = 32'h0;
        do_read(32'h10, 32'h55ADBEEF, "rd_after_nosel");

        // Halfword write immediately followed by a read of the same word.
        do_write(32'h20, 3'b010, 32'h11223344, "wr_fwd_base");
        drive_addr(1'b1, 32'h20, 3'b001);
        step();
        HWDATA = 32'h1234A5A5;
        drive_addr(1'b0, 32'h20, 3'b010);
        exp_q.push_back(32'h1122A5A5);
        wait_ready("fwd_wr");
        step();
        drive_idle();
        HWDATA = 32'h0;
        wait_ready("fwd_rd");
        pop_check("fwd_rd");
        step();
        do_read(32'h20, 32'h1122A5A5, "rd_fwd_committed");

        // Pipelined back-to-back reads.
        drive_addr(1'b0, 32'h10, 3'b010);
        exp_q.push_back(32'h55ADBEEF);
        step();
        drive_addr(1'b0, 32'h20, 3'b010);
        exp_q.push_back(32'h1122A5A5);
        wait_ready("pipe_rd0");
        pop_check("pipe_rd0");
        step();
        drive_idle();
        wait_ready("pipe_rd1");
        pop_check("pipe_rd1");
        step();

        // Reset asserted during a write data phase.
        do_write(32'h30, 3'b010, 32'hCAFEF00D, "wr_rst_base");
        do_read(32'h30, 32'hCAFEF00D, "rd_rst_base");
        drive_addr(1'b1, 32'h30, 3'b010);
        step();
        drive_idle();
        HWDATA = 32'hBAD0BAD0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_hready", {31'd0, HREADY}, 32'd1);
        check("rst_mid_hresp", {30'd0, HRESP}, 32'd0);
        check("rst_mid_hrdata", HRDATA, 32'd0);
        step();
        reset = 1'b0;
        HWDATA = 32'h0;
        step();
        do_read(32'h30, 32'hCAFEF00D, "rd_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
